ps2_keyboard_rx: RTL and testbench



---
 rtl/ps2_pkg.sv | 34 +++
 rtl/ps2_keyboard_rx_if.sv | 21 ++
 rtl/ps2_frame_rx.sv | 96 +++++++++
 rtl/ps2_keyboard_rx.sv | 99 +++++++++
 tb/tb_ps2_keyboard_rx.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Scan-code constants, ignored-code list and frame-state encoding shared by the PS/2 receiver.
// Pure declarations: no latency, no backpressure.
package ps2_pkg;

    localparam logic [7:0] KEY_UP    = 8'h1D;
    localparam logic [7:0] KEY_DOWN  = 8'h1B;
    localparam logic [7:0] KEY_LEFT  = 8'h1C;
    localparam logic [7:0] KEY_RIGHT = 8'h23;

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

    // Keyboard status/ack bytes that never carry a key event.
    localparam int             N_IGNORED     = 6;
    localparam logic [8*N_IGNORED-1:0] IGNORED_CODES =
        {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

    function automatic logic is_ignored(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_IGNORED; i++) begin
            if (b == IGNORED_CODES[i*8 +: 8]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// PS/2 line inputs and decoded key outputs of the keyboard receiver.
// Receiver side is the slave modport; the keyboard/consumer side is the master.
interface ps2_keyboard_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key;
    logic       key_valid;
    logic [7:0] key_held;
    logic       extended;
    logic       rx_err;

    modport slave (
        input  ps2_clk, ps2_data,
        output key, key_valid, key_held, extended, rx_err
    );

    modport master (
        output ps2_clk, ps2_data,
        input  key, key_valid, key_held, extended, rx_err
    );
endinterface

// File: rtl/ps2_frame_rx.sv
// Synchronises and glitch-filters the PS/2 lines and deframes 11-bit odd-parity frames.
// byte_valid/frame_err are combinational in the STOP-bit fall cycle; no backpressure, aborts after timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [1:0]            r_clk_sync;
    logic [1:0]            r_dat_sync;
    logic [FILTER_LEN-1:0] r_filt_sr;
    logic                  r_clk_filt;
    frame_state_t          r_state;
    logic [2:0]            r_bit_cnt;
    logic [7:0]            r_shift;
    logic                  r_parity;
    logic [TW-1:0]         r_tmo_cnt;

    logic w_fall;
    logic w_data;
    logic w_frame_ok;

    assign w_data     = r_dat_sync[1];
    assign w_fall     = r_clk_filt && (r_filt_sr == '0);
    assign w_frame_ok = w_data && (^{r_shift, r_parity});

    assign o_byte       = r_shift;
    assign o_byte_valid = (r_state == STOP) && w_fall && w_frame_ok;
    assign o_frame_err  = (r_state == STOP) && w_fall && !w_frame_ok;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_filt_sr  <= '1;
            r_clk_filt <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[0], i_ps2_data};
            r_filt_sr  <= {r_filt_sr[FILTER_LEN-2:0], r_clk_sync[1]};
            if (r_filt_sr == '0)      r_clk_filt <= 1'b0;
            else if (r_filt_sr == '1) r_clk_filt <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_tmo_cnt <= '0;
        end else if (r_state != IDLE && !w_fall && r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            // Stalled frame: drop it quietly so a later start bit resynchronises.
            r_state   <= IDLE;
            r_tmo_cnt <= '0;
        end else begin
            if (r_state == IDLE || w_fall) r_tmo_cnt <= '0;
            else                           r_tmo_cnt <= r_tmo_cnt + 1'b1;

            if (w_fall) begin
                case (r_state)
                    IDLE: begin
                        if (!w_data) begin
                            r_state   <= DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        r_shift   <= {w_data, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) r_state <= PARITY;
                    end
                    PARITY: begin
                        r_parity <= w_data;
                        r_state  <= STOP;
                    end
                    STOP:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: turns E0/F0-prefixed scan codes into one-cycle make-code pulses.
// Key pulse one clk after the STOP-bit fall event; no backpressure. PS2_TYPEMATIC_FILTER_EN suppresses repeats.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic             clk,
    input  logic             rst_n,
    ps2_keyboard_rx_if.slave bus
);

    logic [7:0] w_byte;
    logic       w_byte_valid;
    logic       w_frame_err;
    logic       w_same;
    logic       w_suppress;

    logic [7:0] r_key;
    logic       r_key_valid;
    logic [7:0] r_key_held;
    logic       r_extended;
    logic       r_rx_err;
    logic       r_ext_pfx;
    logic       r_brk_pfx;

    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_rx (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_ps2_clk   (bus.ps2_clk),
        .i_ps2_data  (bus.ps2_data),
        .o_byte      (w_byte),
        .o_byte_valid(w_byte_valid),
        .o_frame_err (w_frame_err)
    );

    assign w_same = (w_byte == r_key_held) && (r_ext_pfx == r_extended);

`ifdef PS2_TYPEMATIC_FILTER_EN
    assign w_suppress = w_same;
`else
    assign w_suppress = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key       <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= '0;
            r_extended  <= 1'b0;
            r_rx_err    <= 1'b0;
            r_ext_pfx   <= 1'b0;
            r_brk_pfx   <= 1'b0;
        end else begin
            r_key       <= '0;
            r_key_valid <= 1'b0;
            r_rx_err    <= 1'b0;
            if (w_frame_err) begin
                r_rx_err  <= 1'b1;
                r_ext_pfx <= 1'b0;
                r_brk_pfx <= 1'b0;
            end else if (w_byte_valid) begin
                if (w_byte == PFX_EXT) begin
                    r_ext_pfx <= 1'b1;
                end else if (w_byte == PFX_BRK) begin
                    r_brk_pfx <= 1'b1;
                end else if (!is_ignored(w_byte)) begin
                    r_ext_pfx <= 1'b0;
                    r_brk_pfx <= 1'b0;
                    if (r_brk_pfx) begin
                        // Release only clears the key it actually names.
                        if (w_same) begin
                            r_key_held <= '0;
                            r_extended <= 1'b0;
                        end
                    end else begin
                        if (!w_suppress) begin
                            r_key       <= w_byte;
                            r_key_valid <= 1'b1;
                        end
                        r_key_held <= w_byte;
                        r_extended <= r_ext_pfx;
                    end
                end
            end
        end
    end

    assign bus.key       = r_key;
    assign bus.key_valid = r_key_valid;
    assign bus.key_held  = r_key_held;
    assign bus.extended  = r_extended;
    assign bus.rx_err    = r_rx_err;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: directed PS/2 frames against a scan-code level model of key events.
module tb_ps2_keyboard_rx;
    import ps2_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ps2_keyboard_rx_if bus();

    ps2_keyboard_rx dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #20 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: what the keyboard has told us, in scan-code terms.
    logic [7:0] m_held = 8'h00;
    logic       m_extd = 1'b0;
    logic       m_ext  = 1'b0;
    logic       m_brk  = 1'b0;
    logic [8:0] exp_q[$];
    int         exp_err  = 0;
    bit         settled  = 1'b0;
    int         n_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit tb_ignored(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] b, input bit good);
        bit repeat_key;
        if (!good) begin
            exp_err++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (!tb_ignored(b)) begin
            repeat_key = (b == m_held) && (m_ext == m_extd);
            if (m_brk) begin
                if (repeat_key) begin
                    m_held = 8'h00;
                    m_extd = 1'b0;
                end
            end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                if (!repeat_key) exp_q.push_back({m_ext, b});
`else
                exp_q.push_back({m_ext, b});
`endif
                m_held = b;
                m_extd = m_ext;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.key_valid || bus.key != 8'h00) begin
                n_pulses++;
                check("pulse_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    automatic logic [8:0] e = exp_q.pop_front();
                    check("pulse_key", bus.key, e[7:0]);
                    check("pulse_valid", bus.key_valid, 1);
                    check("pulse_ext", bus.extended, e[8]);
                end
            end
            if (bus.rx_err) begin
                check("rx_err_expected", exp_err > 0, 1);
                if (exp_err > 0) exp_err--;
            end
            if (settled) begin
                check("key_held", bus.key_held, m_held);
                check("extended", bus.extended, m_extd);
            end
        end
    end

    // One PS/2 bit: data set while clock high, then a 20-cycle low phase.
    // lat = negedges after the falling edge until key_valid or rx_err (0 if none).
    task automatic ps2_bit(input logic d, output int lat);
        @(negedge clk);
        bus.ps2_data = d;
        repeat (10) @(negedge clk);
        bus.ps2_clk = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (lat == 0 && (bus.key_valid || bus.rx_err)) lat = i;
        end
        bus.ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, output int lat);
        int   l;
        logic p;
        settled = 1'b0;
        model_byte(b, !bad_par);
        p = (~^b) ^ bad_par;
        ps2_bit(1'b0, l);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], l);
        ps2_bit(p, l);
        ps2_bit(1'b1, lat);
        bus.ps2_data = 1'b1;
        repeat (20) @(negedge clk);
        settled = 1'b1;
    endtask

    task automatic send_partial(input int nbits);
        int   l;
        logic [7:0] pat;
        pat = 8'b1101_0110;
        ps2_bit(1'b0, l);
        for (int i = 0; i < nbits; i++) ps2_bit(pat[i], l);
        bus.ps2_data = 1'b1;
    endtask

    initial begin
        int lat;
        int p0;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_key", bus.key, 8'h00);
        check("rst_key_valid", bus.key_valid, 0);
        check("rst_key_held", bus.key_held, 8'h00);
        check("rst_extended", bus.extended, 0);
        check("rst_rx_err", bus.rx_err, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        settled = 1'b1;

        // Single press: 2 sync + 8 filter + 1 decode register after the raw edge.
        p0 = n_pulses;
        send_frame(KEY_UP, 1'b0, lat);
        check("t1_latency", lat, 11);
        check("t1_held", bus.key_held, 8'h1D);

        send_frame(PFX_BRK, 1'b0, lat);
        send_frame(KEY_UP, 1'b0, lat);
        check("t2_release_no_pulse", lat, 0);
        check("t2_held", bus.key_held, 8'h00);
        check("t2_pulses", n_pulses - p0, 1);

        // Extended key with an ignored byte between prefix and code.
        send_frame(8'hE0, 1'b0, lat);
        send_frame(8'hAA, 1'b0, lat);
        send_frame(8'h75, 1'b0, lat);
        check("t3_latency", lat, 11);
        check("t3_held", bus.key_held, 8'h75);
        check("t3_ext", bus.extended, 1);
        send_frame(8'hE0, 1'b0, lat);
        send_frame(8'hF0, 1'b0, lat);
        send_frame(8'h75, 1'b0, lat);
        check("t3_rel_held", bus.key_held, 8'h00);
        check("t3_rel_ext", bus.extended, 0);

        // Parity error, then recovery.
        send_frame(KEY_LEFT, 1'b1, lat);
        check("t4_err_latency", lat, 11);
        check("t4_held", bus.key_held, 8'h00);
        send_frame(KEY_RIGHT, 1'b0, lat);
        check("t4_latency", lat, 11);
        check("t4_held2", bus.key_held, 8'h23);

        // Truncated frame aborted by the 1 ms timeout.
        send_partial(4);
        repeat (26000) @(negedge clk);
        send_frame(KEY_DOWN, 1'b0, lat);
        check("t5_latency", lat, 11);
        check("t5_held", bus.key_held, 8'h1B);

        // Typematic repeat.
        p0 = n_pulses;
        send_frame(KEY_UP, 1'b0, lat);
        send_frame(KEY_UP, 1'b0, lat);
`ifdef PS2_TYPEMATIC_FILTER_EN
        check("t6_pulses", n_pulses - p0, 1);
`else
        check("t6_pulses", n_pulses - p0, 2);
`endif

        // Reset in the middle of a frame.
        send_partial(5);
        settled = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t7_rst_key", bus.key, 8'h00);
        check("t7_rst_valid", bus.key_valid, 0);
        check("t7_rst_held", bus.key_held, 8'h00);
        check("t7_rst_ext", bus.extended, 0);
        check("t7_rst_err", bus.rx_err, 0);
        m_held = 8'h00;
        m_extd = 1'b0;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        exp_q.delete();
        exp_err = 0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        settled = 1'b1;
        send_frame(KEY_UP, 1'b0, lat);
        check("t7_latency", lat, 11);
        check("t7_held", bus.key_held, 8'h1D);

        check("end_pulses_drained", exp_q.size(), 0);
        check("end_errs_drained", exp_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
